// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM (FETCH/DECODE/EXECUTE/MEM/WB) for an RV32I-subset datapath.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             zero_flag,
   input  logic             instr_ready,
   input  logic             mem_ready,
   output logic             instr_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src,
   output logic             mem_to_reg,
   output logic [1:0]       alu_op,
   output logic [2:0]       state,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_FAULT   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_FETCH   = 2'b10;
   localparam logic [1:0] FC_MEM     = 2'b11;

   // A missing ready on wait cycle number MEM_TIMEOUT is the timeout.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [6:0] opcode_q, opcode_d;
   logic [7:0] wait_q, wait_d;
   logic       fault_q, fault_d;
   logic [1:0] fault_code_q, fault_code_d;
   logic [2:0] alu_ctrl_s;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_LW, OP_SW, OP_BEQ: is_legal = 1'b1;
         default:                          is_legal = 1'b0;
      endcase
   endfunction

   // Returns {alu_src, alu_op}
   function automatic logic [2:0] alu_ctrl(input logic [6:0] op);
      case (op)
         OP_R:         alu_ctrl = 3'b0_10;
         OP_I:         alu_ctrl = 3'b1_11;
         OP_LW, OP_SW: alu_ctrl = 3'b1_00;
         OP_BEQ:       alu_ctrl = 3'b0_01;
         default:      alu_ctrl = 3'b0_00;
      endcase
   endfunction

   // Next-state, opcode latch, wait counter and fault capture
   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      wait_d       = 8'd0;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      case (state_q)
         S_FETCH: begin
            if (run) begin
               if (instr_ready) begin
                  state_d = S_DECODE;
               end else if (wait_q == WAIT_LAST) begin
                  state_d      = S_FAULT;
                  fault_d      = 1'b1;
                  fault_code_d = FC_FETCH;
               end else begin
                  wait_d = wait_q + 8'd1;
               end
            end else begin
               wait_d = 8'd0;
            end
         end
         S_DECODE: begin
            opcode_d = opcode;
            if (is_legal(opcode)) begin
               state_d = S_EXECUTE;
            end else begin
               state_d      = S_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_ILLEGAL;
            end
         end
         S_EXECUTE: begin
            if (opcode_q == OP_LW || opcode_q == OP_SW) begin
               state_d = S_MEM;
            end else if (opcode_q == OP_BEQ) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (mem_ready) begin
               state_d = (opcode_q == OP_LW) ? S_WB : S_FETCH;
            end else if (wait_q == WAIT_LAST) begin
               state_d      = S_FAULT;
               fault_d      = 1'b1;
               fault_code_d = FC_MEM;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB:    state_d = S_FETCH;
         S_FAULT: state_d = S_FAULT;
         default: begin
            state_d = S_FAULT;
            fault_d = 1'b1;
         end
      endcase
   end

   // Controller state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         opcode_q     <= 7'd0;
         wait_q       <= 8'd0;
         fault_q      <= 1'b0;
         fault_code_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         wait_q       <= wait_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   assign alu_ctrl_s = alu_ctrl(opcode_q);

   // Datapath controls; everything reads 0 while reset is high
   always_comb begin
      instr_req  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      alu_op     = 2'b00;
      state      = 3'd0;
      fault      = 1'b0;
      fault_code = 2'b00;
      if (!reset) begin
         state      = state_q;
         fault      = fault_q;
         fault_code = fault_code_q;
         case (state_q)
            S_FETCH: begin
               instr_req = run;
               ir_write  = run & instr_ready;
            end
            S_EXECUTE: begin
               {alu_src, alu_op} = alu_ctrl_s;
               if (opcode_q == OP_BEQ) begin
                  pc_write = 1'b1;
                  pc_src   = zero_flag;
               end else begin
                  pc_write = 1'b0;
               end
            end
            S_MEM: begin
               {alu_src, alu_op} = alu_ctrl_s;
               if (opcode_q == OP_LW) begin
                  mem_read = 1'b1;
               end else begin
                  mem_write = 1'b1;
                  pc_write  = mem_ready;
               end
            end
            S_WB: begin
               {alu_src, alu_op} = alu_ctrl_s;
               reg_write  = 1'b1;
               mem_to_reg = (opcode_q == OP_LW);
               pc_write   = 1'b1;
            end
            default: begin
               instr_req = 1'b0;
            end
         endcase
      end else begin
         state = 3'd0;
      end
   end

`ifdef PERF_CNT_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

   // Cycle counter freezes once the controller has faulted
   always_comb begin
      if (state_q != S_FAULT) begin
         cycle_cnt_d = cycle_cnt_q + CNT_ONE;
      end else begin
         cycle_cnt_d = cycle_cnt_q;
      end
      if (pc_write) begin
         retired_cnt_d = retired_cnt_q + CNT_ONE;
      end else begin
         retired_cnt_d = retired_cnt_q;
      end
   end

   // Performance counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q   <= '0;
         retired_cnt_q <= '0;
      end else begin
         cycle_cnt_q   <= cycle_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   assign cycle_cnt   = reset ? '0 : cycle_cnt_q;
   assign retired_cnt = reset ? '0 : retired_cnt_q;
`else
   assign cycle_cnt   = '0;
   assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle phase list (FETCH waits, DECODE, EXECUTE, MEM waits, WB).
module tb_multicycle_controller;
   localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef struct packed {
      logic [2:0] st;
      logic       instr_req;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       fault;
      logic [1:0] fault_code;
   } exp_t;

   typedef struct packed {
      logic       run;
      logic       rdy_i;
      logic       rdy_m;
      logic       zf;
      logic [6:0] op;
      exp_t       e;
   } step_t;

   logic clk = 1'b0;
   logic reset, run, zero_flag, instr_ready, mem_ready;
   logic [6:0] opcode;
   logic instr_req, ir_write, pc_write, pc_src, reg_write, mem_read, mem_write;
   logic alu_src, mem_to_reg, fault;
   logic [1:0] alu_op, fault_code;
   logic [2:0] state;
   logic [CNT_W-1:0] retired_cnt, cycle_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   step_t trace[$];
   logic [CNT_W-1:0] model_cycles, model_retired, exp_ret, exp_cyc;
   bit model_fault = 1'b0;
   logic [6:0] legal_ops [5] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ};

   multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .zero_flag(zero_flag),
      .instr_ready(instr_ready), .mem_ready(mem_ready), .instr_req(instr_req),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
      .alu_op(alu_op), .state(state), .fault(fault), .fault_code(fault_code),
      .retired_cnt(retired_cnt), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   // Cycles since reset, frozen while the model says the controller is faulted
   always @(posedge clk) begin
      if (reset) model_cycles <= '0;
      else if (!model_fault) model_cycles <= model_cycles + 1'b1;
   end

   function automatic exp_t observed();
      exp_t o;
      o.st = state;           o.instr_req = instr_req;   o.ir_write = ir_write;
      o.pc_write = pc_write;  o.pc_src = pc_src;         o.reg_write = reg_write;
      o.mem_read = mem_read;  o.mem_write = mem_write;   o.alu_src = alu_src;
      o.mem_to_reg = mem_to_reg; o.alu_op = alu_op;      o.fault = fault;
      o.fault_code = fault_code;
      return o;
   endfunction

   function automatic exp_t with_alu(input exp_t e, input logic [6:0] op);
      exp_t r = e;
      case (op)
         OP_R:         begin r.alu_src = 1'b0; r.alu_op = 2'b10; end
         OP_I:         begin r.alu_src = 1'b1; r.alu_op = 2'b11; end
         OP_LW, OP_SW: begin r.alu_src = 1'b1; r.alu_op = 2'b00; end
         OP_BEQ:       begin r.alu_src = 1'b0; r.alu_op = 2'b01; end
         default:      r = e;
      endcase
      return r;
   endfunction

   function automatic step_t rnd_step(input logic [2:0] st);
      step_t s = '0;
      s.run = 1'($urandom);  s.rdy_i = 1'($urandom);
      s.rdy_m = 1'($urandom); s.zf = 1'($urandom);
      s.op = 7'($urandom);   s.e.st = st;
      return s;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction
   function automatic void build_trace(input logic [6:0] op, input int idle, input int fd,
                                       input int md, input logic zf);
      step_t s;
      trace.delete();
      for (int i = 0; i < idle; i++) begin
         s = rnd_step(3'd0); s.run = 1'b0; trace.push_back(s);
      end
      for (int i = 0; i <= fd; i++) begin
         s = rnd_step(3'd0); s.run = 1'b1; s.rdy_i = (i == fd);
         s.e.instr_req = 1'b1; s.e.ir_write = (i == fd); trace.push_back(s);
      end
      s = rnd_step(3'd1); s.op = op; trace.push_back(s);
      s = rnd_step(3'd2); s.e = with_alu(s.e, op);
      if (op == OP_BEQ) begin
         s.zf = zf; s.e.pc_write = 1'b1; s.e.pc_src = zf;
      end
      trace.push_back(s);
      if (op == OP_LW || op == OP_SW) begin
         for (int i = 0; i <= md; i++) begin
            s = rnd_step(3'd3); s.rdy_m = (i == md); s.e = with_alu(s.e, op);
            s.e.mem_read = (op == OP_LW); s.e.mem_write = (op == OP_SW);
            s.e.pc_write = (op == OP_SW) && (i == md);
            trace.push_back(s);
         end
      end
      if (op == OP_R || op == OP_I || op == OP_LW) begin
         s = rnd_step(3'd4); s.e = with_alu(s.e, op);
         s.e.reg_write = 1'b1; s.e.mem_to_reg = (op == OP_LW); s.e.pc_write = 1'b1;
         trace.push_back(s);
      end
   endfunction

   task automatic apply(input step_t s);
      run = s.run; instr_ready = s.rdy_i; mem_ready = s.rdy_m;
      zero_flag = s.zf; opcode = s.op;
   endtask

   task automatic do_reset();
      model_fault = 1'b0; model_retired = '0;
      reset = 1'b1; apply(rnd_step(3'd0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      exp_t got;
      model_fault = 1'b0; model_retired = '0;
      reset = 1'b1; run = 1'b1; instr_ready = 1'b1; mem_ready = 1'b1;
      opcode = OP_R; zero_flag = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1; got = observed(); n_checks++;
         if (got !== exp_t'(0) || retired_cnt !== '0 || cycle_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: got %b ret=%0d cyc=%0d, expected all zero", i, got, retired_cnt, cycle_cnt);
         end
         @(negedge clk);
      end
      reset = 1'b0; run = 1'b0;
      #1; got = observed(); n_checks++;
      exp_cyc = PERF ? model_cycles : '0;
      if (got !== exp_t'(0) || cycle_cnt !== exp_cyc) begin
         n_fail++;
         $display("FAIL reset_release: got %b cyc=%0d, expected all zero cyc=%0d", got, cycle_cnt, exp_cyc);
      end
      @(negedge clk);
   endtask

   task automatic test_run_gate();
      exp_t got;
      build_trace(OP_R, 20, 14, 0, 1'b0);
      foreach (trace[k]) begin
         apply(trace[k]); #1; got = observed(); n_checks++;
         if (got !== trace[k].e) begin
            n_fail++; $display("FAIL run_gate step %0d: got %b, expected %b", k, got, trace[k].e);
         end
         @(negedge clk);
      end
      model_retired++;
   endtask

   task automatic test_directed();
      exp_t got;
      logic [6:0] ops [9] = '{OP_R, OP_I, OP_LW, OP_SW, OP_BEQ, OP_BEQ, OP_SW, OP_LW, OP_I};
      int fds [9] = '{0, 0, 0, 0, 0, 0, 0, 14, 2};
      int mds [9] = '{0, 0, 3, 0, 0, 0, 14, 1, 0};
      logic zfs [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 9; c++) begin
         build_trace(ops[c], 0, fds[c], mds[c], zfs[c]);
         foreach (trace[k]) begin
            apply(trace[k]); #1; got = observed(); n_checks++;
            if (got !== trace[k].e) begin
               n_fail++; $display("FAIL directed[%0d] step %0d: got %b, expected %b", c, k, got, trace[k].e);
            end
            @(negedge clk);
         end
         model_retired++;
      end
      #1; n_checks++;
      exp_ret = PERF ? model_retired : '0;
      exp_cyc = PERF ? model_cycles : '0;
      if (retired_cnt !== exp_ret || cycle_cnt !== exp_cyc) begin
         n_fail++;
         $display("FAIL directed_counters: got ret=%0d cyc=%0d, expected ret=%0d cyc=%0d", retired_cnt, cycle_cnt, exp_ret, exp_cyc);
      end
      @(negedge clk);
   endtask

   task automatic test_faults();
      exp_t got, fexp;
      logic [6:0] ops [3] = '{7'b1111111, OP_R, OP_SW};
      int fds [3] = '{0, 20, 0};
      int mds [3] = '{0, 0, 20};
      int nplay [3] = '{2, 15, 18};
      logic [1:0] codes [3] = '{2'b01, 2'b10, 2'b11};
      for (int c = 0; c < 3; c++) begin
         do_reset();
         build_trace(ops[c], 0, fds[c], mds[c], 1'b0);
         for (int k = 0; k < nplay[c]; k++) begin
            apply(trace[k]); #1; got = observed(); n_checks++;
            if (got !== trace[k].e) begin
               n_fail++; $display("FAIL fault_lead[%0d] step %0d: got %b, expected %b", c, k, got, trace[k].e);
            end
            @(negedge clk);
         end
         fexp = '0; fexp.st = 3'd7; fexp.fault = 1'b1; fexp.fault_code = codes[c];
         model_fault = 1'b1;
         for (int i = 0; i < 12; i++) begin
            apply(rnd_step(3'd7)); #1; got = observed(); n_checks++;
            if (got !== fexp) begin
               n_fail++; $display("FAIL fault_hold[%0d] cyc %0d: got %b, expected %b", c, i, got, fexp);
            end
            @(negedge clk);
         end
         #1; n_checks++;
         exp_ret = '0;
         exp_cyc = PERF ? model_cycles : '0;
         if (retired_cnt !== exp_ret || cycle_cnt !== exp_cyc) begin
            n_fail++;
            $display("FAIL fault_counters[%0d]: got ret=%0d cyc=%0d, expected ret=%0d cyc=%0d", c, retired_cnt, cycle_cnt, exp_ret, exp_cyc);
         end
         do_reset();
         run = 1'b0; #1; got = observed(); n_checks++;
         if (got !== exp_t'(0)) begin
            n_fail++; $display("FAIL fault_cleared[%0d]: got %b, expected all zero", c, got);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      exp_t got;
      step_t s;
      do_reset();
      build_trace(OP_LW, 0, 0, 5, 1'b0);
      for (int k = 0; k < 5; k++) begin
         apply(trace[k]); #1; got = observed(); n_checks++;
         if (got !== trace[k].e) begin
            n_fail++; $display("FAIL reset_mid_lead step %0d: got %b, expected %b", k, got, trace[k].e);
         end
         @(negedge clk);
      end
      model_retired = '0; model_fault = 1'b0;
      reset = 1'b1; s = rnd_step(3'd0); s.rdy_m = 1'b1; apply(s);
      #1; got = observed(); n_checks++;
      if (got !== exp_t'(0)) begin
         n_fail++; $display("FAIL reset_in_mem: got %b, expected all zero", got);
      end
      @(negedge clk);
      reset = 1'b0; run = 1'b0;
      #1; got = observed(); n_checks++;
      if (got !== exp_t'(0) || retired_cnt !== '0) begin
         n_fail++; $display("FAIL reset_mid_after: got %b ret=%0d, expected all zero ret=0", got, retired_cnt);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      exp_t got;
      logic [6:0] op;
      for (int n = 0; n < 40; n++) begin
         op = legal_ops[$urandom_range(0, 4)];
         build_trace(op, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
         foreach (trace[k]) begin
            apply(trace[k]); #1; got = observed(); n_checks++;
            if (got !== trace[k].e) begin
               n_fail++; $display("FAIL random[%0d] op %b step %0d: got %b, expected %b", n, op, k, got, trace[k].e);
            end
            @(negedge clk);
         end
         model_retired++;
      end
      #1; n_checks++;
      exp_ret = PERF ? model_retired : '0;
      exp_cyc = PERF ? model_cycles : '0;
      if (retired_cnt !== exp_ret || cycle_cnt !== exp_cyc) begin
         n_fail++;
         $display("FAIL random_counters: got ret=%0d cyc=%0d, expected ret=%0d cyc=%0d", retired_cnt, cycle_cnt, exp_ret, exp_cyc);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_run_gate();
      test_directed();
      test_faults();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle sequencer for the RV32I subset datapath. It replaces single-cycle control with an FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It generates every datapath enable and handshakes with variable-latency instruction and data memories. It sits beside the datapath: it takes opcode and the ALU zero flag in, and drives the mux selects and write enables out.

Parameters:
MEM_TIMEOUT, 15, max wait cycles for instr_ready/mem_ready before fault (1..255)
CNT_W, 32, width of the performance counters (optional feature)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
run  in  1  1 = allow a new fetch to start; sampled only in FETCH before instr_req is issued
opcode  in  7  instruction[6:0] from the instruction register
zero_flag  in  1  ALU zero flag
instr_ready  in  1  instruction memory has valid data this cycle
mem_ready  in  1  data memory completed the read/write this cycle
instr_req  out  1  fetch request, held until instr_ready
ir_write  out  1  one-cycle pulse capturing the instruction
pc_write  out  1  one-cycle PC update pulse (retire)
pc_src  out  1  0 = PC+4, 1 = PC+imm
reg_write  out  1  register file write enable
mem_read  out  1  data read request, held until mem_ready
mem_write  out  1  data write request, held until mem_ready
alu_src  out  1  0 = rs2, 1 = immediate
mem_to_reg  out  1  0 = ALU result, 1 = memory data
alu_op  out  2  00 add, 01 sub, 10 R-type funct, 11 I-ALU funct
state  out  3  current FSM state (debug)
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 illegal opcode, 10 fetch timeout, 11 memory timeout
retired_cnt  out  CNT_W  retired instructions (optional feature)
cycle_cnt  out  CNT_W  cycles since reset (optional feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=7. Register state, opcode_q and an 8-bit wait counter.
- Outputs are combinational from state, opcode_q and the ready inputs. No output is registered except fault, fault_code and the counters.
- Reset: state=FETCH, wait counter=0, fault=0, fault_code=00, counters=0. With reset high every output is 0. Reset mid-instruction abandons the instruction: no pc_write and no reg_write.
- FETCH: instr_req=run. When run=1 and instr_ready=1, assert ir_write and go to DECODE. If run=0, stay in FETCH and leave the wait counter at 0.
- DECODE: latch opcode into opcode_q. Legal opcodes are 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW) and 1100011 (BEQ); these go to EXECUTE. Any other opcode goes to FAULT with code 01.
- EXECUTE, by opcode:
  - R: alu_src=0, alu_op=10, next state WB.
  - I-ALU: alu_src=1, alu_op=11, next state WB.
  - LW/SW: alu_src=1, alu_op=00, next state MEM.
  - BEQ: alu_src=0, alu_op=01, pc_write=1, pc_src=zero_flag, next state FETCH (retire).
- MEM:
  - alu_src and alu_op hold their EXECUTE values.
  - LW: mem_read=1 until mem_ready, then go to WB.
  - SW: mem_write=1 until mem_ready. On the mem_ready cycle, pc_write=1, pc_src=0, next state FETCH (retire).
- WB: reg_write=1, mem_to_reg=1 for LW and 0 otherwise, pc_write=1, pc_src=0, next state FETCH (retire). ALU selects hold their EXECUTE values.
- Wait counter:
  - Counts cycles spent in FETCH (with run=1) or MEM without the ready input.
  - Clears on ready or on any state change.
  - If the counter reaches MEM_TIMEOUT without ready, go to FAULT with code 10 (FETCH) or 11 (MEM).
  - A ready arriving on the same cycle as the timeout wins: no fault.
- FAULT: all enables 0, fault=1. Sticky until reset.
- Latency with ready asserted immediately: R/I = 4 cycles, LW = 5, SW = 4, BEQ = 3 (FETCH to retire inclusive).
- Exactly one pc_write per retired instruction. pc_write and ir_write are never asserted together.

Optional Feature:
PERF_CNT_EN:
- Defined: cycle_cnt increments every cycle out of reset and freezes in FAULT. retired_cnt increments on every pc_write. Both wrap modulo 2^CNT_W.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- R-type 0110011, run=1, readies=1 -> states 0,1,2,4. reg_write=1 only in cycle 4. pc_write=1 once. alu_op=10.
- LW 0000011 with mem_ready delayed 3 cycles -> mem_read held 4 cycles. WB has mem_to_reg=1 and reg_write=1. Total 8 cycles. retired_cnt=1 with PERF_CNT_EN.
- BEQ with zero_flag=1, then zero_flag=0 -> EXECUTE shows pc_write=1 with pc_src=1, then pc_src=0. reg_write stays 0 for both.
- Opcode 1111111 -> FAULT, fault_code=01, all enables 0 for 10+ cycles. reset=1 for one cycle -> state=0, fault=0.
- SW with mem_ready never asserted, MEM_TIMEOUT=15 -> FAULT with code 11 after 15 wait cycles. Repeat with mem_ready on the 15th cycle -> no fault, retire.
- Assert reset in MEM of an LW -> next cycle state=FETCH, no reg_write and no pc_write.
